fru_config_sequencer: RTL and testbench

FRU_CONFIG_SEQUENCER -- requirements
Module: fru_config_sequencer

---
 rtl/fru_config_sequencer_pkg.sv | 40 ++++
 rtl/cfg_byte_deserializer.sv | 48 ++++
 rtl/fru_config_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fru_config_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fru_config_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fru_config_sequencer_pkg
// Purpose : Shared definitions for the filter reduce unit (FRU) and its
//           configuration sequencer. Contents: the sequencer state encoding,
//           the packet opcodes and the firmware table-select encodings.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fru_config_sequencer_pkg;

    // Sequencer states. The width is fixed at 3 bits and every encoding is
    // explicit so the FRU and the sequencer always agree on the values.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_SEL    = 3'd1,
        T_CHAIN  = 3'd2,
        T_VAL    = 3'd3,
        V_ADDR   = 3'd4,
        V_DATA   = 3'd5,
        V_COMMIT = 3'd6
    } seq_state_e;

    // First byte of a packet selects the packet type.
    localparam logic [7:0] c_OPC_TABLE = 8'h01;  // firmware table write
    localparam logic [7:0] c_OPC_VRF   = 8'h02;  // FU vector register write

    // Firmware table selects. Encoding 3 is reserved and is rejected.
    localparam logic [1:0] c_TBL_FILTER_OP   = 2'd0;
    localparam logic [1:0] c_TBL_FILTER_ADDR = 2'd1;
    localparam logic [1:0] c_TBL_REDUCE_OP   = 2'd2;
    localparam logic [1:0] c_TBL_INVALID     = 2'd3;

    // A table select names a real table unless it is the reserved code.
    function automatic logic fw_table_valid(input logic [1:0] i_tbl);
        return (i_tbl != c_TBL_INVALID);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_byte_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : cfg_byte_deserializer
// Purpose : Collects configuration bytes into one wide word. The first byte
//           of a word ends up in the most significant byte position.
// Ports   : clk        - clock
//           rst_n      - asynchronous active-low reset
//           i_shift_en - shift i_byte into the word this cycle
//           i_byte     - incoming byte
//           o_word     - word formed by the stored bytes followed by i_byte;
//                        complete when i_byte is the last byte of the word
// Revision: 1.0 - initial release
// ============================================================================
module cfg_byte_deserializer #(
    parameter int BYTES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_shift_en,
    input  logic [7:0]         i_byte,
    output logic [BYTES*8-1:0] o_word
);

    if (BYTES > 1) begin : g_shift
        // Only BYTES-1 bytes need storage: the final byte is taken straight
        // from i_byte, so the full word is available in the cycle the last
        // byte is accepted.
        localparam int c_SW = (BYTES - 1) * 8;

        logic [c_SW-1:0]      r_shift;
        logic [BYTES*8-1:0]   w_next;

        assign w_next = {r_shift, i_byte};
        assign o_word = w_next;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shift <= '0;
            end else if (i_shift_en) begin
                r_shift <= w_next[c_SW-1:0];
            end
        end
    end else begin : g_single
        assign o_word = i_byte;
    end

endmodule
`default_nettype wire

// File: rtl/fru_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fru_config_sequencer
// Purpose : Decodes the byte-serial configuration stream addressed to this
//           FRU into firmware-table writes and FU vector register file
//           (FUVRF) writes, and gates tracing while a packet is in flight.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           cfg_valid, configId,
//           configData            - configuration byte stream
//           tracing_in/out        - tracing request in, gated tracing out
//           fw_we, fw_table,
//           fw_chain, fw_data     - firmware table write port
//           vrf_we, vrf_addr,
//           vrf_data              - FUVRF port-b write port
//           busy                  - packet in progress
//           err                   - one-cycle error pulse
// Revision: 1.0 - initial release
// ============================================================================
module fru_config_sequencer
    import fru_config_sequencer_pkg::*;
#(
    parameter int N                  = 8,
    parameter int M                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter int FUVRF_SIZE         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic                          tracing_in,
    output logic                          tracing_out,
    output logic                          fw_we,
    output logic [1:0]                    fw_table,
    output logic [$clog2(MAX_CHAINS)-1:0] fw_chain,
    output logic [7:0]                    fw_data,
    output logic                          vrf_we,
    output logic [$clog2(FUVRF_SIZE)-1:0] vrf_addr,
    output logic [M*DATA_WIDTH-1:0]       vrf_data,
    output logic                          busy,
    output logic                          err
);

    localparam int c_BYTES = (M * DATA_WIDTH) / 8;
    localparam int c_CNT_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam int c_CH_W  = $clog2(MAX_CHAINS);
    localparam int c_AW    = $clog2(FUVRF_SIZE);
    localparam logic [c_CNT_W-1:0] c_LAST_BYTE = c_CNT_W'(c_BYTES - 1);

    // The word must split evenly into bytes and the FRU needs real lanes.
    if (N < 1 || M < 1 || ((M * DATA_WIDTH) % 8) != 0) begin : g_param_check
        $error("fru_config_sequencer: invalid N/M/DATA_WIDTH combination");
    end

    seq_state_e               r_state;
    logic [1:0]               r_table;
    logic [7:0]               r_chain;     // full byte kept for range check
    logic [7:0]               r_fw_data;
    logic [7:0]               r_addr;      // full byte kept for range check
    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_fw_we;
    logic                     r_vrf_we;
    logic                     r_err;
    logic [M*DATA_WIDTH-1:0]  r_vrf_data;

    logic                     w_acc;
    logic                     w_shift_en;
    logic                     w_fw_bad;
    logic                     w_addr_bad;
    logic                     w_busy;
    logic [M*DATA_WIDTH-1:0]  w_word;

    // Bytes for other units are ignored outright.
    assign w_acc      = cfg_valid && (configId == 8'(PERSONAL_CONFIG_ID));
    assign w_shift_en = w_acc && (r_state == V_DATA);
    assign w_fw_bad   = !fw_table_valid(r_table) ||
                        ({24'h0, r_chain} >= 32'(MAX_CHAINS));
    assign w_addr_bad = ({24'h0, r_addr} >= 32'(FUVRF_SIZE));
    assign w_busy     = (r_state != IDLE);

    cfg_byte_deserializer #(
        .BYTES (c_BYTES)
    ) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_shift_en (w_shift_en),
        .i_byte     (configData),
        .o_word     (w_word)
    );

    // Strobes are registered: they are set on the edge that accepts the
    // deciding byte and fall back to 0 on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_table    <= '0;
            r_chain    <= '0;
            r_fw_data  <= '0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_fw_we    <= 1'b0;
            r_vrf_we   <= 1'b0;
            r_err      <= 1'b0;
            r_vrf_data <= '0;
        end else begin
            r_fw_we  <= 1'b0;
            r_vrf_we <= 1'b0;
            r_err    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (configData == c_OPC_TABLE) begin
                            r_state <= T_SEL;
                        end else if (configData == c_OPC_VRF) begin
                            r_state <= V_ADDR;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                T_SEL: begin
                    if (w_acc) begin
                        r_table <= configData[1:0];
                        r_state <= T_CHAIN;
                    end
                end
                T_CHAIN: begin
                    if (w_acc) begin
                        r_chain <= configData;
                        r_state <= T_VAL;
                    end
                end
                T_VAL: begin
                    // A bad table or chain still consumes the value byte so
                    // the packet framing stays intact.
                    if (w_acc) begin
                        r_fw_data <= configData;
                        if (w_fw_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_fw_we <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                V_ADDR: begin
                    if (w_acc) begin
                        r_addr  <= configData;
                        r_cnt   <= '0;
                        r_state <= V_DATA;
                    end
                end
                V_DATA: begin
                    if (w_acc) begin
                        if (r_cnt == c_LAST_BYTE) begin
                            // vrf_data only changes on entry to V_COMMIT, and
                            // never for an out-of-range address.
                            if (w_addr_bad) begin
                                r_err <= 1'b1;
                            end else begin
                                r_vrf_we   <= 1'b1;
                                r_vrf_data <= w_word;
                            end
                            r_state <= V_COMMIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                V_COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fw_we       = r_fw_we;
    assign fw_table    = r_table;
    assign fw_chain    = r_chain[c_CH_W-1:0];
    assign fw_data     = r_fw_data;
    assign vrf_we      = r_vrf_we;
    assign vrf_addr    = r_addr[c_AW-1:0];
    assign vrf_data    = r_vrf_data;
    assign err         = r_err;
    assign busy        = w_busy;
    // rst_n is included so tracing is forced off during reset itself.
    assign tracing_out = tracing_in && !w_busy && rst_n;

endmodule
`default_nettype wire

// File: tb/tb_fru_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fru_config_sequencer
// Purpose : Self-checking bench for fru_config_sequencer (default parameters).
//           Expected write/error strobes are queued when a packet is sent and
//           compared as the DUT produces them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fru_config_sequencer;

    localparam int W = 256;
    localparam logic [1:0] K_FW  = 2'd0;
    localparam logic [1:0] K_VRF = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cfg_valid = 1'b0;
    logic [7:0]   configId = 8'h00;
    logic [7:0]   configData = 8'h00;
    logic         tracing_in = 1'b0;
    logic         tracing_out;
    logic         fw_we;
    logic [1:0]   fw_table;
    logic [1:0]   fw_chain;
    logic [7:0]   fw_data;
    logic         vrf_we;
    logic [1:0]   vrf_addr;
    logic [W-1:0] vrf_data;
    logic         busy;
    logic         err;

    typedef struct {
        logic [1:0]   kind;
        logic [1:0]   tbl;
        logic [1:0]   chain;
        logic [7:0]   data;
        logic [1:0]   addr;
        logic [W-1:0] word;
    } exp_t;

    typedef struct {
        logic [7:0] tsel;
        logic [7:0] chain;
        logic [7:0] val;
        logic       exp_err;
    } tvec_t;

    exp_t       exp_q[$];
    tvec_t      vec[8];
    int         n_checks = 0;
    int         n_fail = 0;
    int         busy_total = 0;
    exp_t       mon_e;
    logic [1:0] mon_kind;

    fru_config_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .configId    (configId),
        .configData  (configData),
        .tracing_in  (tracing_in),
        .tracing_out (tracing_out),
        .fw_we       (fw_we),
        .fw_table    (fw_table),
        .fw_chain    (fw_chain),
        .fw_data     (fw_data),
        .vrf_we      (vrf_we),
        .vrf_addr    (vrf_addr),
        .vrf_data    (vrf_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_fw(input logic [1:0] t, input logic [1:0] c, input logic [7:0] d);
        exp_t e;
        e = '{kind: K_FW, tbl: t, chain: c, data: d, addr: 2'd0, word: '0};
        exp_q.push_back(e);
    endtask

    task automatic push_vrf(input logic [1:0] a, input logic [W-1:0] w);
        exp_t e;
        e = '{kind: K_VRF, tbl: 2'd0, chain: 2'd0, data: 8'd0, addr: a, word: w};
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '{kind: K_ERR, tbl: 2'd0, chain: 2'd0, data: 8'd0, addr: 2'd0, word: '0};
        exp_q.push_back(e);
    endtask

    // Monitor: sample away from the active edge, compare strobes in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_total++;
            chk("tracing_out", W'(tracing_out), W'(tracing_in & ~busy));
            if (fw_we || vrf_we || err) begin
                mon_kind = fw_we ? K_FW : (vrf_we ? K_VRF : K_ERR);
                chk("strobe_exclusive", W'(fw_we & vrf_we), '0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got kind %0d required none", mon_kind);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind", W'(mon_kind), W'(mon_e.kind));
                    if (mon_e.kind == K_FW) begin
                        chk("fw_table", W'(fw_table), W'(mon_e.tbl));
                        chk("fw_chain", W'(fw_chain), W'(mon_e.chain));
                        chk("fw_data", W'(fw_data), W'(mon_e.data));
                    end else if (mon_e.kind == K_VRF) begin
                        chk("vrf_addr", W'(vrf_addr), W'(mon_e.addr));
                        chk("vrf_data", vrf_data, mon_e.word);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] id, input logic [7:0] d, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        cfg_valid  = 1'b1;
        configId   = id;
        configData = d;
        @(posedge clk);
        #1;
        cfg_valid  = 1'b0;
        configData = 8'h00;
    endtask

    // Wait (bounded) for the packet to finish, then confirm every queued
    // strobe has been seen.
    task automatic drain();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", W'(k < 100), W'(1));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("sb_empty", W'(exp_q.size()), '0);
    endtask

    task automatic tbl_pkt(input logic [7:0] tsel, input logic [7:0] chain,
                           input logic [7:0] val, input logic exp_err, input bit chk_busy);
        int b0;
        b0 = busy_total;
        if (exp_err) push_err();
        else push_fw(tsel[1:0], chain[1:0], val);
        send_byte(8'h00, 8'h01, 0);
        send_byte(8'h00, tsel, 0);
        send_byte(8'h00, chain, 0);
        send_byte(8'h00, val, 0);
        drain();
        if (chk_busy) chk("tbl_busy_cycles", W'(busy_total - b0), W'(3));
    endtask

    task automatic vrf_pkt(input logic [7:0] addr, input int mul, input int add,
                           input int max_gap, input bit chk_busy, output logic [W-1:0] word);
        logic [7:0] b;
        int b0;
        word = '0;
        b0 = busy_total;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * mul + add);
            word[W-1-8*i -: 8] = b;
        end
        if (addr < 8'd4) push_vrf(addr[1:0], word);
        else push_err();
        send_byte(8'h00, 8'h02, (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
        send_byte(8'h00, addr, (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * mul + add);
            send_byte(8'h00, b, (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
        end
        drain();
        if (chk_busy) chk("vrf_busy_cycles", W'(busy_total - b0), W'(34));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_strobes", W'({fw_we, vrf_we, err}), '0);
        chk("rst_busy_trace", W'({busy, tracing_out}), '0);
        chk("rst_fw_fields", W'({fw_table, fw_chain, fw_data}), '0);
        chk("rst_vrf_addr", W'(vrf_addr), '0);
        chk("rst_vrf_data", vrf_data, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        logic [W-1:0] w3;
        int b0;

        // table select, chain, value, expect error
        vec[0] = '{8'h02, 8'h03, 8'h5A, 1'b0};
        vec[1] = '{8'h00, 8'h00, 8'h11, 1'b0};
        vec[2] = '{8'h01, 8'h01, 8'hC3, 1'b0};
        vec[3] = '{8'h03, 8'h00, 8'h44, 1'b1};
        vec[4] = '{8'h00, 8'h05, 8'hAA, 1'b1};
        vec[5] = '{8'h01, 8'h02, 8'hFF, 1'b0};
        vec[6] = '{8'h02, 8'h04, 8'h77, 1'b1};
        vec[7] = '{8'h06, 8'h01, 8'h3C, 1'b0};

        tracing_in = 1'b1;
        #2 rst_n = 1'b0;
        #2 chk_reset_outputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 8; i++) begin
            tbl_pkt(vec[i].tsel, vec[i].chain, vec[i].val, vec[i].exp_err, 1'b1);
        end

        // FUVRF writes: back-to-back, random gaps, other address, bad address
        vrf_pkt(8'h01, 1, 0, 0, 1'b1, w1);
        vrf_pkt(8'h01, 1, 0, 5, 1'b0, w2);
        chk("vrf_gap_word_same", w2, w1);
        vrf_pkt(8'h03, 7, 3, 2, 1'b0, w3);
        vrf_pkt(8'h04, 1, 128, 0, 1'b1, w2);
        chk("vrf_data_hold_after_err", vrf_data, w3);

        // Unknown opcode: error pulse, never busy
        b0 = busy_total;
        push_err();
        send_byte(8'h00, 8'h07, 0);
        drain();
        chk("bad_opc_busy", W'(busy_total - b0), '0);

        // Bytes for another unit must not move the state machine
        b0 = busy_total;
        send_byte(8'h01, 8'h01, 0);
        send_byte(8'h01, 8'h02, 0);
        send_byte(8'h01, 8'h5A, 1);
        drain();
        chk("other_id_busy", W'(busy_total - b0), '0);
        tbl_pkt(8'h00, 8'h01, 8'h99, 1'b0, 1'b1);

        // Reset after 10 of 32 data bytes, then a normal table write
        send_byte(8'h00, 8'h02, 0);
        send_byte(8'h00, 8'h01, 0);
        for (int i = 0; i < 10; i++) send_byte(8'h00, 8'(i), 0);
        rst_n = 1'b0;
        #2 chk_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tbl_pkt(8'h02, 8'h03, 8'h5A, 1'b0, 1'b1);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("sb_final_empty", W'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
